switch_led_ctrl: RTL and testbench
==================================

SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

Interface
REQ-001 SHALL have parameter N_SW, default 4: number of active-low switch inputs (2..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: stable cycles required before a switch change is accepted (>=1).
REQ-003 SHALL have parameter BLINK_HALF, default 1000: clock cycles per blink half-period (>=2).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port sw_n, input, N_SW: raw switches, active low (pressed = 0), asynchronous to clk.
REQ-007 SHALL have port led_green, output, 1: green LED, active high.
REQ-008 SHALL have port led_blue, output, 1: blue LED, active high.
REQ-009 SHALL have port mode, output, 2: current mode encoding (IDLE=0, BLUE=1, GREEN=2).
REQ-010 SHALL have port pressed, output, N_SW: debounced pressed vector, 1 = pressed.

Function
REQ-011 SHALL pass each sw_n bit through a 2-flop synchronizer and invert it, so that 1 = pressed.
REQ-012 SHALL accept a new synchronized value per switch only after it has stayed unchanged for DEBOUNCE_CYCLES consecutive cycles; any toggle before that restarts the count.
REQ-013 SHALL compute popcount of pressed with width $clog2(N_SW+1).
REQ-014 SHALL register the mode one cycle after pressed updates:
- popcount 0 -> IDLE
- popcount odd -> GREEN
- popcount even and nonzero -> BLUE
REQ-015 SHALL allow any-to-any state transitions; the FSM SHALL have exactly the states IDLE, BLUE and GREEN, and the unused encoding 3 SHALL recover to IDLE on the next cycle.
REQ-016 SHALL drive BLUE as led_blue=1, led_green=0.
REQ-017 SHALL drive GREEN as led_blue=0, led_green=1.
REQ-018 SHALL drive IDLE as led_green=0 and led_blue=blink.
REQ-019 SHALL run the blink counter only in IDLE: it counts 0..BLINK_HALF-1, and blink toggles on wrap.
REQ-020 SHALL start blink=1 with the counter at 0 on every entry into IDLE.
REQ-021 SHALL hold blink=0 with the counter cleared outside IDLE.
REQ-022 SHALL register all LED outputs, giving a latency from a clean sw_n edge to the LED of 2 + DEBOUNCE_CYCLES + 2 cycles.
REQ-023 SHALL, when several switches change in the same cycle, debounce each one independently; mode follows the resulting vector with no intermediate glitch state beyond one per accepted update.

Reset
REQ-024 SHALL force, on rst=1 regardless of clk, all of the following:
- synchronizers and pressed to 0 (released)
- debounce counters to 0
- mode to IDLE
- blink counter to 0, blink to 1
- led_green=0, led_blue=1
REQ-025 SHALL, on rst deassertion, resume with IDLE blinking from a fresh phase; a reset asserted mid-debounce discards the pending change.

Configuration
REQ-026 SHALL, with SWLED_DEBOUNCE_EN defined, implement the REQ-012 debounce.
REQ-027 SHALL, without SWLED_DEBOUNCE_EN, drive pressed directly from the synchronizer output (latency 2 + 2 cycles), instantiate no debounce counters, and ignore DEBOUNCE_CYCLES.

Structure
REQ-028 SHALL take the mode encodings (IDLE/BLUE/GREEN), the mode width constant and the popcount helper function from shared package swled_pkg.
REQ-029 SHALL implement the synchronizer plus debounce in one sub-module, swled_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated N_SW times in a generate loop.

Verification
REQ-030 SHALL verify reset defaults: assert rst mid-run -> immediately mode=0, led_green=0, led_blue=1, pressed=0.
REQ-031 SHALL verify debounce rejection: with defaults, pulse sw_n[0] low for 10 cycles -> pressed stays 0 and mode stays IDLE; hold it low for 20 cycles -> pressed=4'b0001 and mode=GREEN 2+16+1 cycles after the edge.
REQ-032 SHALL verify parity mapping: press switches 0 and 2 -> mode=BLUE, led_blue=1, led_green=0; then press switch 3 as well -> mode=GREEN; then press all 4 -> mode=BLUE.
REQ-033 SHALL verify the blink period: with BLINK_HALF=4 and all switches released, led_blue follows 1111 0000 1111 repeating from IDLE entry; press and release one switch -> the phase restarts at 1.
REQ-034 SHALL verify simultaneous events: with N_SW=8, release 3 switches in the same cycle from 5 pressed -> a single update with popcount 2 -> BLUE.
REQ-035 SHALL verify the build without SWLED_DEBOUNCE_EN: a 3-cycle low pulse on sw_n[1] -> pressed[1] high for 3 cycles, and mode GREEN then IDLE.

Source files
------------

// File: rtl/swled_pkg.sv
// swled_pkg: shared mode encodings, mode width and popcount helper for switch_led_ctrl
package swled_pkg;
  localparam int MODE_W = 2;
  localparam int MAX_SW = 16;
  typedef enum logic [MODE_W-1:0] {IDLE = 2'd0, BLUE = 2'd1, GREEN = 2'd2} mode_t;
  function automatic logic [4:0] popcount(input logic [MAX_SW-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_SW; i++) popcount = popcount + 5'(v[i]);
  endfunction
endpackage

// File: rtl/swled_debounce.sv
// swled_debounce: one-bit 2-flop synchronizer with inversion, debounced when SWLED_DEBOUNCE_EN is defined
module swled_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  output logic pressed
);
  logic s1, s2;
  // two-flop synchronizer, stored inverted so 1 = pressed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~sw_n;
      s2 <= s1;
    end
`ifdef SWLED_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  // accept s2 once it has differed from pressed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      cnt     <= (s2 == pressed || cnt == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt + 1'b1;
      pressed <= (s2 != pressed && cnt == CW'(DEBOUNCE_CYCLES - 1)) ? s2 : pressed;
    end
`else
  logic unused_dc;
  assign unused_dc = DEBOUNCE_CYCLES > 0;
  assign pressed = s2;
`endif
endmodule

// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: switch popcount parity drives IDLE/BLUE/GREEN LED modes; debounce enabled by SWLED_DEBOUNCE_EN
module switch_led_ctrl
  import swled_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw_n,
  output logic              led_green,
  output logic              led_blue,
  output logic [MODE_W-1:0] mode,
  output logic [N_SW-1:0]   pressed
);
  localparam int PC_W = $clog2(N_SW + 1);
  localparam int BW   = $clog2(BLINK_HALF);
  mode_t           state, nxt;
  logic [PC_W-1:0] pc;
  logic [BW-1:0]   bcnt;
  logic            blink, wrap;
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    swled_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .sw_n    (sw_n[i]),
      .pressed (pressed[i])
    );
  end
  assign pc   = PC_W'(popcount(MAX_SW'(pressed)));
  assign mode = state;
  assign wrap = bcnt == BW'(BLINK_HALF - 1);
  // next mode from parity of the debounced vector; the unused encoding falls back to IDLE
  always_comb
    nxt = (mode == 2'd3 || pc == '0) ? IDLE : pc[0] ? GREEN : BLUE;
  // mode register, blink phase that restarts on IDLE entry, and registered LEDs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      blink     <= 1'b1;
      led_green <= 1'b0;
      led_blue  <= 1'b1;
    end else begin
      state     <= nxt;
      led_green <= state == GREEN;
      led_blue  <= state == BLUE || (state == IDLE && blink);
      bcnt      <= (nxt != IDLE || state != IDLE || wrap) ? '0 : bcnt + 1'b1;
      blink     <= nxt != IDLE ? 1'b0 : state != IDLE ? 1'b1 : wrap ? ~blink : blink;
    end
endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb_switch_led_ctrl: directed stimulus with a per-cycle behavioural model check for switch_led_ctrl
module tb_switch_led_ctrl;
  localparam int N  = 8;
  localparam int D  = 16;
  localparam int BH = 4;
`ifdef SWLED_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_n = '1;
  logic         led_green, led_blue;
  logic [1:0]   mode;
  logic [N-1:0] pressed;
  int checks = 0;
  int errors = 0;

  switch_led_ctrl #(.N_SW(N), .DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_n      (sw_n),
    .led_green (led_green),
    .led_blue  (led_blue),
    .mode      (mode),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  // model: hist[k] is the pressed-sense switch sample taken k edges ago
  logic [N-1:0] hist [0:D];
  logic [N-1:0] m_pressed, m_next;
  int           m_mode, idle_run;
  logic         m_green, m_blue;

  function automatic int mode_of(input logic [N-1:0] p);
    int c = $countones(p);
    return c == 0 ? 0 : (c % 2 == 1) ? 2 : 1;
  endfunction

  function automatic logic blink_of(input int run);
    return ((run - 1) / BH) % 2 == 0;
  endfunction

`ifdef SWLED_DEBOUNCE_EN
  logic [N-1:0] all1, all0;
  always_comb begin
    all1 = '1;
    all0 = '1;
    for (int k = 1; k <= D; k++) begin
      all1 &= hist[k];
      all0 &= ~hist[k];
    end
    m_next = (m_pressed | all1) & ~all0;
  end
`else
  always_comb m_next = hist[0];
`endif

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k <= D; k++) hist[k] <= '0;
      m_pressed <= '0;
      m_mode    <= 0;
      idle_run  <= 1;
      m_green   <= 1'b0;
      m_blue    <= 1'b1;
    end else begin
      hist[0] <= ~sw_n;
      for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
      m_pressed <= m_next;
      m_mode    <= mode_of(m_pressed);
      idle_run  <= mode_of(m_pressed) != 0 ? 0 : m_mode == 0 ? idle_run + 1 : 1;
      m_green   <= m_mode == 2;
      m_blue    <= m_mode == 1 || (m_mode == 0 && blink_of(idle_run));
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_pressed", int'(pressed), int'(m_pressed));
    chk("model_mode", int'(mode), m_mode);
    chk("model_led_green", int'(led_green), int'(m_green));
    chk("model_led_blue", int'(led_blue), int'(m_blue));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [11:0] seq;
    logic [5:0]  pv;
    logic [1:0]  last;
    int          chg, bad, w, m3, m6;
    ticks(3);
    chk("reset_mode", int'(mode), 0);
    chk("reset_led_blue", int'(led_blue), 1);
    chk("reset_led_green", int'(led_green), 0);
    chk("reset_pressed", int'(pressed), 0);
    rst = 1'b0;
    seq = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seq = {seq[10:0], led_blue};
    end
    chk("blink_after_reset", int'(seq), int'(12'b111100001111));
`ifdef SWLED_DEBOUNCE_EN
    bad = 0;
    sw_n[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 10) sw_n[0] = 1'b1;
      if (pressed != '0 || mode != 2'd0) bad++;
    end
    chk("reject_short_pulse", bad, 0);
`else
    pv = '0;
    m3 = -1;
    m6 = -1;
    sw_n[1] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      pv = {pv[4:0], pressed[1]};
      if (i == 3) begin
        sw_n[1] = 1'b1;
        m3 = int'(mode);
      end
      if (i == 6) m6 = int'(mode);
    end
    chk("nodeb_pulse_pressed", int'(pv), int'(6'b011100));
    chk("nodeb_pulse_mode_green", m3, 2);
    chk("nodeb_pulse_mode_idle", m6, 0);
`endif
    ticks(LAT + 4);
    sw_n[0] = 1'b0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      if (i == LAT - 1) chk("hold_pressed_before", int'(pressed), 0);
      if (i == LAT) chk("hold_pressed_at", int'(pressed), 1);
      if (i == LAT) chk("hold_mode_before", int'(mode), 0);
      if (i == LAT + 1) chk("hold_mode_green", int'(mode), 2);
      if (i == LAT + 2) chk("hold_led_green", int'(led_green), 1);
    end
    sw_n[2] = 1'b0;
    ticks(LAT + 3);
    chk("p02_mode", int'(mode), 1);
    chk("p02_led_blue", int'(led_blue), 1);
    chk("p02_led_green", int'(led_green), 0);
    sw_n[3] = 1'b0;
    ticks(LAT + 3);
    chk("p023_mode", int'(mode), 2);
    sw_n[1] = 1'b0;
    ticks(LAT + 3);
    chk("p0123_mode", int'(mode), 1);
    chk("p0123_pressed", int'(pressed), 'h0F);
    sw_n[4] = 1'b0;
    ticks(LAT + 3);
    chk("five_mode", int'(mode), 2);
    sw_n[4] = 1'b1;
    sw_n[3] = 1'b1;
    sw_n[1] = 1'b1;
    chg = 0;
    last = mode;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (mode != last) chg++;
      last = mode;
    end
    chk("simul_updates", chg, 1);
    chk("simul_mode", int'(mode), 1);
    chk("simul_pressed", int'(pressed), 'h05);
    sw_n = '1;
    ticks(LAT + 4);
    chk("released_mode", int'(mode), 0);
    sw_n[5] = 1'b0;
    ticks(LAT + 3);
    chk("one_mode", int'(mode), 2);
    sw_n[5] = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (mode != 2'd0 && w < LAT + 5);
    chk("reentry_idle", int'(mode), 0);
    seq = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seq = {seq[10:0], led_blue};
    end
    chk("blink_after_reentry", int'(seq), int'(12'b111100001111));
    sw_n[0] = 1'b0;
    ticks(8);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_led_green", int'(led_green), 0);
    chk("async_rst_led_blue", int'(led_blue), 1);
    chk("async_rst_pressed", int'(pressed), 0);
    ticks(2);
    rst = 1'b0;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      if (i == LAT - 1) chk("post_rst_pressed_before", int'(pressed), 0);
      if (i == LAT) chk("post_rst_pressed_at", int'(pressed), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
